// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter/sequencer. Round-robin grant, single-cycle
// write strobe, (RD_LATENCY+1)-cycle read strobe, registered ack/err/rdata.
// Addresses below MAP_BASE complete with an error ack and never strobe the bus.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] MAP_BASE = 'h1001_0024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  bus_wr_en,
  output logic                  bus_rd_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t          state, state_nxt;
  logic            we_q;
  logic            owner;
  logic            last_owner;
  logic [3:0]      cnt;
  logic            elig0, elig1;
  logic            gnt, gnt_sel, done;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // A master still seeing its own ack this cycle is not eligible, so a held
  // req cannot be regranted on the ack cycle.
  assign elig0 = m0_req & ~m0_ack;
  assign elig1 = m1_req & ~m1_ack;

  assign bus_wr_en = (state == BUSY) &  we_q;
  assign bus_rd_en = (state == BUSY) & ~we_q;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: arbitration in IDLE, completion detect in BUSY/ERR.
  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    gnt_sel   = 1'b0;
    done      = 1'b0;
    sel_addr  = m0_addr;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt      = 1'b1;
          gnt_sel  = (elig0 & elig1) ? ~last_owner : elig1;
          sel_addr = gnt_sel ? m1_addr : m0_addr;
          state_nxt = (sel_addr < MAP_BASE) ? ERR : BUSY;
        end
      end
      BUSY: begin
        if (we_q || cnt == 4'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latch, read-latency counter and per-master response regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= 4'd0;
      grant_id   <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      if (gnt) begin
        owner      <= gnt_sel;
        last_owner <= gnt_sel;
        grant_id   <= gnt_sel;
        we_q       <= gnt_sel ? m1_we : m0_we;
        bus_addr   <= sel_addr;
        bus_wdata  <= gnt_sel ? m1_wdata : m0_wdata;
        cnt        <= (gnt_sel ? m1_we : m0_we) ? 4'd0 : 4'(RD_LATENCY);
      end
      if (state == BUSY && !we_q && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (done) begin
        if (owner) begin
          m1_ack <= 1'b1;
          m1_err <= (state == ERR);
          if (state == BUSY && !we_q) m1_rdata <= bus_rdata;
        end else begin
          m0_ack <= 1'b1;
          m0_err <= (state == ERR);
          if (state == BUSY && !we_q) m0_rdata <= bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table-driven bench for mem_bus_arbiter. One instance with
// RD_LATENCY=1 runs the table; a second with RD_LATENCY=3 shares the inputs
// and is used for the mid-transaction reset sequence.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic        m0_ack, m0_err, m1_ack, m1_err, bus_wr_en, bus_rd_en, busy, grant_id;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;

  logic        x0_ack, x0_err, x1_ack, x1_err, x_wr_en, x_rd_en, x_busy, x_gid;
  logic [31:0] x0_rdata, x1_rdata, x_addr, x_wdata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_bus_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(x0_ack), .m0_err(x0_err), .m0_rdata(x0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(x1_ack), .m1_err(x1_err), .m1_rdata(x1_rdata),
    .bus_wr_en(x_wr_en), .bus_rd_en(x_rd_en), .bus_addr(x_addr),
    .bus_wdata(x_wdata), .bus_rdata(bus_rdata), .busy(x_busy), .grant_id(x_gid)
  );

  // inp = {m0_req, m0_we, m1_req, m1_we}
  // exp = {wr_en, rd_en, m0_ack, m0_err, m1_ack, m1_err, busy, grant_id}
  typedef struct {
    logic [3:0]  inp;
    logic [31:0] a0, d0, a1, brd;
    logic [7:0]  exp;
    logic [31:0] ea, ewd, er0, er1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] inp, input logic [31:0] a0, d0, a1, brd,
                     input logic [7:0] exp, input logic [31:0] ea, ewd, er0, er1);
    vq.push_back('{inp, a0, d0, a1, brd, exp, ea, ewd, er0, er1});
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    else pass_cnt++;
  endtask

  task automatic idle_in();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 32'h1111_1111;
    bus_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] flags();
    return {bus_wr_en, bus_rd_en, m0_ack, m0_err, m1_ack, m1_err, busy, grant_id};
  endfunction

  initial begin
    int ack_at;
    int rd_cycles;
    logic m0_seen;

    // S1: write, data changes during BUSY are ignored
    add(4'b1100, 32'h7FFF_EF00, 32'hDEAD_BEEF, 0, 0, 8'b00000000, 0, 0, 0, 0);
    add(4'b1100, 32'hFFFF_0000, 0, 0, 0, 8'b10000010, 32'h7FFF_EF00, 32'hDEAD_BEEF, 0, 0);
    add(4'b1100, 32'hFFFF_0000, 0, 0, 0, 8'b00100000, 32'h7FFF_EF00, 32'hDEAD_BEEF, 0, 0);
    add(4'b0000, 0, 0, 0, 0, 8'b00000000, 32'h7FFF_EF00, 32'hDEAD_BEEF, 0, 0);
    // S2: m1 read, latency 1
    add(4'b0010, 0, 0, 32'h1001_002C, 32'h41, 8'b00000000, 32'h7FFF_EF00, 32'hDEAD_BEEF, 0, 0);
    add(4'b0010, 0, 0, 32'h1001_002C, 32'h41, 8'b01000011, 32'h1001_002C, 32'h1111_1111, 0, 0);
    add(4'b0010, 0, 0, 32'h1001_002C, 32'h41, 8'b01000011, 32'h1001_002C, 32'h1111_1111, 0, 0);
    add(4'b0010, 0, 0, 32'h1001_002C, 32'h41, 8'b00001001, 32'h1001_002C, 32'h1111_1111, 0, 32'h41);
    add(4'b0000, 0, 0, 32'h1001_002C, 32'h41, 8'b00000001, 32'h1001_002C, 32'h1111_1111, 0, 32'h41);
    // S3: both read continuously, round robin m0,m1,m0,m1
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b00000001, 32'h1001_002C, 32'h1111_1111, 0, 32'h41);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b01000010, 32'h1001_0030, 0, 0, 32'h41);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hA0, 8'b01000010, 32'h1001_0030, 0, 0, 32'h41);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b00100000, 32'h1001_0030, 0, 32'hA0, 32'h41);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b01000011, 32'h1001_002C, 32'h1111_1111, 32'hA0, 32'h41);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hA1, 8'b01000011, 32'h1001_002C, 32'h1111_1111, 32'hA0, 32'h41);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b00001001, 32'h1001_002C, 32'h1111_1111, 32'hA0, 32'hA1);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b01000010, 32'h1001_0030, 0, 32'hA0, 32'hA1);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hA2, 8'b01000010, 32'h1001_0030, 0, 32'hA0, 32'hA1);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b00100000, 32'h1001_0030, 0, 32'hA2, 32'hA1);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b01000011, 32'h1001_002C, 32'h1111_1111, 32'hA2, 32'hA1);
    add(4'b1010, 32'h1001_0030, 0, 32'h1001_002C, 32'hA3, 8'b01000011, 32'h1001_002C, 32'h1111_1111, 32'hA2, 32'hA1);
    add(4'b0010, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b00001001, 32'h1001_002C, 32'h1111_1111, 32'hA2, 32'hA3);
    add(4'b0000, 32'h1001_0030, 0, 32'h1001_002C, 32'hFF, 8'b00000001, 32'h1001_002C, 32'h1111_1111, 32'hA2, 32'hA3);
    // S4: unmapped read -> error ack, no strobe, rdata kept
    add(4'b1000, 32'h0000_0100, 0, 0, 32'hBB, 8'b00000001, 32'h1001_002C, 32'h1111_1111, 32'hA2, 32'hA3);
    add(4'b1000, 32'h0000_0100, 0, 0, 32'hBB, 8'b00000010, 32'h0000_0100, 0, 32'hA2, 32'hA3);
    add(4'b1000, 32'h0000_0100, 0, 0, 32'hBB, 8'b00110000, 32'h0000_0100, 0, 32'hA2, 32'hA3);
    add(4'b0000, 32'h0000_0100, 0, 0, 32'hBB, 8'b00000000, 32'h0000_0100, 0, 32'hA2, 32'hA3);
    // S5: req held through ack, then a second write
    add(4'b1100, 32'h1001_0040, 32'h1234_5678, 0, 0, 8'b00000000, 32'h0000_0100, 0, 32'hA2, 32'hA3);
    add(4'b1100, 32'h1001_0040, 32'h1234_5678, 0, 0, 8'b10000010, 32'h1001_0040, 32'h1234_5678, 32'hA2, 32'hA3);
    add(4'b1100, 32'h1001_0040, 32'h1234_5678, 0, 0, 8'b00100000, 32'h1001_0040, 32'h1234_5678, 32'hA2, 32'hA3);
    add(4'b1100, 32'h1001_0044, 32'hCAFE_F00D, 0, 0, 8'b00000000, 32'h1001_0040, 32'h1234_5678, 32'hA2, 32'hA3);
    add(4'b1100, 32'h1001_0044, 32'hCAFE_F00D, 0, 0, 8'b10000010, 32'h1001_0044, 32'hCAFE_F00D, 32'hA2, 32'hA3);
    add(4'b1100, 32'h1001_0044, 32'hCAFE_F00D, 0, 0, 8'b00100000, 32'h1001_0044, 32'hCAFE_F00D, 32'hA2, 32'hA3);
    add(4'b0000, 32'h1001_0044, 32'hCAFE_F00D, 0, 0, 8'b00000000, 32'h1001_0044, 32'hCAFE_F00D, 32'hA2, 32'hA3);

    // Reset state
    idle_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_flags", 0, 32'(flags()), 0);
    chk("rst_addr",  0, bus_addr, 0);
    chk("rst_wdata", 0, bus_wdata, 0);
    chk("rst_rd0",   0, m0_rdata, 0);
    chk("rst_rd1",   0, m1_rdata, 0);

    // First tie after reset goes to m0; then reset aborts it
    m0_req = 1; m0_addr = 32'h1001_0030;
    m1_req = 1; m1_addr = 32'h1001_002C;
    tick();
    @(negedge clk);
    chk("tie_flags", 0, 32'(flags()), 32'b01000010);
    rst = 1;
    tick();
    rst = 0;
    idle_in();
    @(negedge clk);
    chk("abort_flags", 0, 32'(flags()), 0);
    tick();
    @(negedge clk);
    chk("abort_noack", 0, 32'(flags()), 0);
    tick();

    // Table
    for (int i = 0; i < vq.size(); i++) begin
      {m0_req, m0_we, m1_req, m1_we} = vq[i].inp;
      m0_addr = vq[i].a0; m0_wdata = vq[i].d0;
      m1_addr = vq[i].a1; bus_rdata = vq[i].brd;
      @(negedge clk);
      chk("flags", i, 32'(flags()), 32'(vq[i].exp));
      chk("bus_addr", i, bus_addr, vq[i].ea);
      chk("bus_wdata", i, bus_wdata, vq[i].ewd);
      chk("m0_rdata", i, m0_rdata, vq[i].er0);
      chk("m1_rdata", i, m1_rdata, vq[i].er1);
      tick();
    end

    // Mid-transaction reset on the RD_LATENCY=3 instance
    idle_in();
    rst = 1; tick(); rst = 0;
    m1_req = 1; m1_addr = 32'h1001_0030;
    tick();
    rst = 1;
    @(negedge clk);
    chk("r3_rd_before", 0, {x_rd_en, x_busy, x_gid}, 3'b111);
    tick();
    rst = 0; m1_req = 0;
    @(negedge clk);
    chk("r3_after", 0, {x_wr_en, x_rd_en, x1_ack, x_busy, x_gid}, 5'b00000);
    tick();
    @(negedge clk);
    chk("r3_noack", 0, {x1_ack, x0_ack}, 2'b00);
    tick();
    // Follow-up m1 read completes normally: ack RD_LATENCY+2 = 5 cycles later
    m1_req = 1; bus_rdata = 32'h77;
    ack_at = -1; rd_cycles = 0; m0_seen = 0;
    for (int k = 0; k < 12 && ack_at < 0; k++) begin
      @(negedge clk);
      if (x_rd_en) rd_cycles++;
      if (x0_ack) m0_seen = 1;
      if (x1_ack) begin
        ack_at = k;
        chk("r3_rdata", 0, x1_rdata, 32'h77);
        chk("r3_err", 0, 32'(x1_err), 0);
      end
      tick();
    end
    m1_req = 0;
    chk("r3_ack_cycle", 0, ack_at, 5);
    chk("r3_rd_cycles", 0, rd_cycles, 4);
    chk("r3_m0_ack", 0, 32'(m0_seen), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the memory-mapped address decoder (data RAM / UART / GPIO).
- Master 0 is the pipeline MEM-stage data port; master 1 is the UART boot loader that writes program/data images.
- Grants one transaction at a time with round-robin fairness and drives single-cycle write strobes and multi-cycle read strobes.
- Returns registered read data and an ack pulse. Accesses below the first mapped peripheral address get an error ack and no bus strobe.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- RD_LATENCY, 1, extra cycles the read strobe is held before read data is sampled; legal range 0..14
- MAP_BASE, 32'h1001_0024, lowest mapped address; any address below it is unmapped

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  master 0 address
- m0_wdata  in  DATA_WIDTH  master 0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  unmapped-access flag, valid with m0_ack
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_ack, held until next m0 read ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: identical for master 1
- bus_wr_en  out  1  write strobe to decoder
- bus_rd_en  out  1  read strobe to decoder
- bus_addr  out  ADDR_WIDTH  latched transaction address
- bus_wdata  out  DATA_WIDTH  latched write data
- bus_rdata  in  DATA_WIDTH  read data from decoder mux
- busy  out  1  transaction in progress
- grant_id  out  1  owner of current/last transaction

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous, active-high.
- Reset values:
  - State IDLE.
  - All ack/err/strobes 0; busy 0.
  - All rdata, bus_addr and bus_wdata 0.
  - grant_id 0; internal last_owner = 1, so master 0 wins the first tie.
  - Reset asserted mid-transaction aborts it: no ack is issued and strobes drop on the next edge.
- States: IDLE, BUSY, ERR.
- IDLE:
  - A master is eligible if its req=1 and its ack=0 in the current cycle. This prevents regranting on the ack cycle while req is still high.
  - One eligible master: grant it. Both eligible: grant the master != last_owner.
  - On grant, at the edge: latch addr/we/wdata/owner, set grant_id, set last_owner = owner, busy=1.
  - If addr < MAP_BASE (unsigned), go to ERR. Otherwise go to BUSY and load cnt = we ? 0 : RD_LATENCY.
- BUSY, write:
  - Exactly one cycle, bus_wr_en=1.
  - At the edge: owner ack=1, err=0, back to IDLE, busy=0.
- BUSY, read:
  - bus_rd_en=1 and bus_addr stable for RD_LATENCY+1 cycles. cnt decrements each cycle.
  - In the cycle cnt==0, at the edge: owner rdata <= bus_rdata, ack=1, err=0, IDLE, busy=0.
- ERR:
  - One cycle, no strobes.
  - At the edge: ack=1, err=1, rdata unchanged, IDLE.
- Latency, with a request first seen in IDLE in cycle 0:
  - Write ack in cycle 2.
  - Read ack in cycle RD_LATENCY+2.
  - Error ack in cycle 2.
  - Earliest regrant to any master is the ack cycle, restricted by the eligibility rule.
- Outputs:
  - ack and err are registered one-cycle pulses.
  - The non-owner's ack stays 0.
  - bus_addr and bus_wdata hold their last values in IDLE; strobes are 0 in IDLE and ERR.
- A request arriving while BUSY waits; no request is dropped.
- Requests that change while BUSY are ignored, because the latched copy is used.

Test Plan:
- m0 write addr 0x7FFF_EF00, data 0xDEAD_BEEF, cycle 0 → bus_wr_en=1 only in cycle 1 with bus_addr=0x7FFF_EF00, bus_wdata=0xDEAD_BEEF; m0_ack=1, m0_err=0 in cycle 2.
- RD_LATENCY=1, m1 read 0x1001_002C, bus_rdata=0x0000_0041 → bus_rd_en high cycles 1–2; m1_ack in cycle 3 with m1_rdata=0x41; m0_ack stays 0.
- m0 and m1 both request reads continuously from reset → grant order m0, m1, m0, m1 (grant_id 0,1,0,1); no master granted twice in a row; each ack pulse is 1 cycle.
- m0 read 0x0000_0100 (< MAP_BASE) → no bus strobes; m0_ack=1, m0_err=1 in cycle 2; m0_rdata keeps its previous value.
- rst asserted in cycle 1 of an m1 read with RD_LATENCY=3 → strobes 0 next cycle; no m1_ack; grant_id=0, busy=0; a following m1 request completes normally.
- m0 holds req through its ack cycle, then issues a new write → exactly one ack per transaction; the second write strobe appears only after the eligibility rule permits regrant.
